fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed 8N1 UART transmitter.
// Imported by the top-level transmitter.
package fifo_uart_pkg;

    localparam int DATA_W    = 8;
    localparam int BIT_IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
        STOP
    } state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Per-bit cycle counter; counts 0..CLKS_PER_BIT-1 while run is high.
// bit_end marks the last cycle of a bit, bit_pre_end the one before it.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end     = run && (cnt_q == CNT_MAX);
    assign bit_pre_end = run && (cnt_q == CNT_PRE);

    always_comb begin
        cnt_d = cnt_q;
        if (!run || bit_end) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops one byte per frame from a FIFO read port.
// All outputs are registered; state transitions are computed in always_comb.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       byte_count
);

    import fifo_uart_pkg::*;

    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_W - 1);

    state_e                state_q;
    state_e                state_d;
    logic [DATA_W-1:0]     shift_q;
    logic [DATA_W-1:0]     shift_d;
    logic [BIT_IDX_W-1:0]  idx_q;
    logic [BIT_IDX_W-1:0]  idx_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  rd_en_q;
    logic                  rd_en_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;
    logic [15:0]           byte_count_q;
    logic [15:0]           byte_count_d;

    logic timer_run;
    logic bit_end;
    logic bit_pre_end;

    assign timer_run = (state_q == START) || (state_q == DATA) || (state_q == STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (timer_run),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        tx_d         = tx_q;
        byte_count_d = byte_count_q;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (en && !fifo_empty) begin
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LOAD;
            end
            // Data arrives the cycle after the pop; the start bit begins with it.
            LOAD: begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[DATA_W-1:1]};
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    byte_count_d = byte_count_q + 16'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_en_d = (state_d == READ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_q == STOP) && bit_pre_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            tx_q         <= 1'b1;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            byte_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            tx_q         <= tx_d;
            rd_en_q      <= rd_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: frame-level model checked every cycle,
// plus hand-computed literal expectations for the directed cases.
module tb_fifo_uart_tx;

    localparam int N     = 4;
    localparam int FRAME = 10 * N;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data = 8'h00;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic [15:0] byte_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_pulses = 0;
    int done_cyc;

    logic [7:0] q[$];

    logic        m_active = 1'b0;
    int          m_c0 = 0;
    logic [7:0]  m_byte = 8'h00;
    logic [15:0] m_count = 16'h0000;

    // Start bit, 0xA5 LSB first, stop bit, indexed by bit slot.
    logic [9:0]  a5_frame = 10'b1_1010_0101_0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(N),
        .DATA_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // FIFO read side: data follows a pop by one cycle.
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en === 1'b1) begin
            rd_pulses++;
            if (q.size() > 0) begin
                fifo_data <= q.pop_front();
            end
        end
        fifo_empty <= (q.size() == 0);
    end

    // Frame-level model: a frame decided in cycle c0 pops at c0+1,
    // starts at c0+3 and spans 10 bit slots of N cycles each.
    always @(negedge clk) begin : model
        int   off;
        int   b;
        logic e_tx;
        logic e_rd;
        logic e_busy;
        logic e_done;
        logic in_frame;
        e_tx   = 1'b1;
        e_rd   = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_count  = 16'h0000;
        end else begin
            if ((!m_active || cyc >= m_c0 + 3 + FRAME) && en && !fifo_empty && q.size() > 0) begin
                m_active = 1'b1;
                m_c0     = cyc;
                m_byte   = q[0];
            end
            off      = cyc - m_c0;
            in_frame = m_active && (off >= 1) && (off < 3 + FRAME);
            if (in_frame) begin
                e_busy = 1'b1;
                e_rd   = (off == 1);
                e_done = (off == 3 + FRAME - 1);
                if (off >= 3) begin
                    b = (off - 3) / N;
                    if (b == 0) e_tx = 1'b0;
                    else if (b <= 8) e_tx = m_byte[b-1];
                    else e_tx = 1'b1;
                end
            end
        end
        chk1("m_tx", tx, e_tx);
        chk1("m_rd_en", fifo_rd_en, e_rd);
        chk1("m_busy", busy, e_busy);
        chk1("m_tx_done", tx_done, e_done);
        chk16("m_byte_count", byte_count, m_count);
        if (e_done) m_count++;
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_rd_en", fifo_rd_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tx_done", tx_done, 1'b0);
        chk16("rst_byte_count", byte_count, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single byte 0xA5 against literal cycle positions.
        @(posedge clk);
        #1 en = 1'b1;
        q.push_back(8'hA5);
        @(negedge clk);
        for (int c = 0; c < 44; c++) begin
            logic e;
            @(negedge clk);
            e = (c < 3 || c >= 39) ? 1'b1 : a5_frame[(c - 3) / N];
            chk1("a5_tx", tx, e);
            chk1("a5_rd_en", fifo_rd_en, c == 1);
            chk1("a5_tx_done", tx_done, c == 42);
        end
        chk16("a5_byte_count", byte_count, 16'd1);

        // Three queued bytes sent back to back.
        do_reset();
        rd_pulses = 0;
        @(posedge clk);
        #1 q.push_back(8'h00);
        q.push_back(8'hFF);
        q.push_back(8'h55);
        repeat (3 * (3 + FRAME) + 10) @(posedge clk);
        #1;
        chki("b2b_rd_pulses", rd_pulses, 3);
        chk16("b2b_byte_count", byte_count, 16'd3);

        // Enabled but empty FIFO.
        rd_pulses = 0;
        repeat (100) @(posedge clk);
        #1;
        chki("empty_rd_pulses", rd_pulses, 0);
        chk1("empty_tx", tx, 1'b1);
        chk1("empty_busy", busy, 1'b0);

        // en drops at cycle 10; frame completes, no further pop.
        rd_pulses = 0;
        @(posedge clk);
        #1 q.push_back(8'h5A);
        q.push_back(8'h96);
        @(negedge clk);
        @(negedge clk);
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        done_cyc = -1;
        for (int c = 10; c < 60; c++) begin
            @(negedge clk);
            if (tx_done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        chki("drop_done_cycle", done_cyc, 42);
        repeat (100) @(posedge clk);
        #1;
        chki("drop_rd_pulses", rd_pulses, 1);
        q.delete();

        // Reset at cycle 20 aborts the frame; next byte goes out intact.
        do_reset();
        @(posedge clk);
        #1 en = 1'b1;
        q.push_back(8'h3C);
        @(negedge clk);
        @(negedge clk);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("midrst_tx", tx, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_tx_done", tx_done, 1'b0);
        chk1("midrst_rd_en", fifo_rd_en, 1'b0);
        q.push_back(8'hC3);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3 + FRAME + 5) @(posedge clk);
        #1;
        chk16("midrst_byte_count", byte_count, 16'd1);

        // byte_count wraps from 0xFFFF to 0x0000.
        @(posedge clk);
        #1 force dut.byte_count_q = 16'hFFFF;
        m_count = 16'hFFFF;
        #1 release dut.byte_count_q;
        @(posedge clk);
        #1 q.push_back(8'h81);
        repeat (3 + FRAME + 6) @(posedge clk);
        #1;
        chk16("wrap_byte_count", byte_count, 16'h0000);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
